// File: rtl/motion_pkg.sv
// -----------------------------------------------------------------------------
// motion_pkg
// Definitions shared by the motion path and the keyboard controller.
//   KEY_*          : bit positions of the direction bits in the keys bus
//   motion_state_t : speed-ramp state encoding (IDLE / RAMP / CRUISE)
// -----------------------------------------------------------------------------
package motion_pkg;

   localparam int KEY_UP    = 0;
   localparam int KEY_LEFT  = 1;
   localparam int KEY_DOWN  = 2;
   localparam int KEY_RIGHT = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RAMP   = 2'd1,
      CRUISE = 2'd2
   } motion_state_t;

endpackage

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running counter that walks 0..TICK_DIV-1 and wraps. It raises a
// single-cycle tick while the count sits at TICK_DIV-1.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the count
//   tick : high for one cycle out of every TICK_DIV
// -----------------------------------------------------------------------------
module tick_divider #(
   parameter int TICK_DIV = 400000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;

   // Count up and wrap at the last value. The tick is decoded from the count
   // itself, so the first tick after reset lands on cycle TICK_DIV-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl
// Turns keyboard direction bits into clamped horizontal/vertical positions for
// one on-screen object. Moves once per tick, ramps speed while a key is held,
// and pulses shift_left/shift_right when hpos actually changes.
//   clk, rst            : clock, synchronous active-high reset
//   keys[3:0]           : up / left / down / right levels
//   load, load_h/load_v : one-cycle position load (values are clamped)
//   hpos, vpos          : current position (registered)
//   shift_left/right    : one-cycle pulse when hpos decreased / increased
//   moving              : state is not IDLE
//   at_h_edge/at_v_edge : position sits on a clamp bound (registered)
// -----------------------------------------------------------------------------
module sprite_motion_ctrl
   import motion_pkg::*;
#(
   parameter int H_BITS      = 10,
   parameter int V_BITS      = 10,
   parameter int H_MIN       = 0,
   parameter int H_MAX       = 639,
   parameter int V_MIN       = 0,
   parameter int V_MAX       = 479,
   parameter int H_INIT      = 200,
   parameter int V_INIT      = 200,
   parameter int TICK_DIV    = 400000,
   parameter int STEP_MIN    = 1,
   parameter int STEP_MAX    = 4,
   parameter int ACCEL_TICKS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        keys,
   input  logic              load,
   input  logic [H_BITS-1:0] load_h,
   input  logic [V_BITS-1:0] load_v,
   output logic [H_BITS-1:0] hpos,
   output logic [V_BITS-1:0] vpos,
   output logic              shift_left,
   output logic              shift_right,
   output logic              moving,
   output logic              at_h_edge,
   output logic              at_v_edge
);

   localparam int SPEED_W = $clog2(STEP_MAX + 1);
   localparam int HOLD_W  = $clog2(ACCEL_TICKS + 1);

   // Signed 32-bit arithmetic keeps pos - speed meaningful below zero, so a
   // move past MIN clamps instead of wrapping even when MIN is 0.
   function automatic int clamp(input int value, input int lo, input int hi);
      if (value < lo) begin
         return lo;
      end else if (value > hi) begin
         return hi;
      end
      return value;
   endfunction

   logic                tick;
   motion_state_t       state, state_n;
   logic [SPEED_W-1:0]  speed, speed_n;
   logic [HOLD_W-1:0]   hold, hold_n;
   logic [H_BITS-1:0]   hpos_n;
   logic [V_BITS-1:0]   vpos_n;
   logic                shift_left_n, shift_right_n;
   logic                key_up, key_left, key_down, key_right;
   logic                has_req;
   int                  h_step, v_step, h_cand, v_cand;

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign key_up    = keys[KEY_UP];
   assign key_left  = keys[KEY_LEFT];
   assign key_down  = keys[KEY_DOWN];
   assign key_right = keys[KEY_RIGHT];

   // Opposing keys on one axis cancel; the axes are independent.
   assign has_req = (key_left ^ key_right) | (key_up ^ key_down);

   // Next-state logic for the speed ramp plus the move for this tick. The
   // move uses the current speed, so a ramp step on this tick only affects
   // the following one.
   always_comb begin
      state_n       = state;
      speed_n       = speed;
      hold_n        = hold;
      hpos_n        = hpos;
      vpos_n        = vpos;
      shift_left_n  = 1'b0;
      shift_right_n = 1'b0;
      h_step        = 0;
      v_step        = 0;

      if (key_left && !key_right) begin
         h_step = -int'(speed);
      end else if (key_right && !key_left) begin
         h_step = int'(speed);
      end
      if (key_up && !key_down) begin
         v_step = -int'(speed);
      end else if (key_down && !key_up) begin
         v_step = int'(speed);
      end

      h_cand = clamp(int'(hpos) + h_step, H_MIN, H_MAX);
      v_cand = clamp(int'(vpos) + v_step, V_MIN, V_MAX);

      if (tick) begin
         if (!has_req) begin
            state_n = IDLE;
            speed_n = SPEED_W'(STEP_MIN);
            hold_n  = '0;
         end else begin
            case (state)
               IDLE: begin
                  state_n = (STEP_MIN == STEP_MAX) ? CRUISE : RAMP;
                  hold_n  = '0;
               end
               RAMP: begin
                  if (hold == HOLD_W'(ACCEL_TICKS - 1)) begin
                     speed_n = speed + 1'b1;
                     hold_n  = '0;
                     if (speed == SPEED_W'(STEP_MAX - 1)) begin
                        state_n = CRUISE;
                     end
                  end else begin
                     hold_n = hold + 1'b1;
                  end
               end
               CRUISE: begin
                  state_n = CRUISE;
               end
               default: begin
                  state_n = IDLE;
                  speed_n = SPEED_W'(STEP_MIN);
                  hold_n  = '0;
               end
            endcase
         end
      end

      // A load overrides the tick's move but not its ramp/state update.
      if (load) begin
         hpos_n = H_BITS'(clamp(int'(load_h), H_MIN, H_MAX));
         vpos_n = V_BITS'(clamp(int'(load_v), V_MIN, V_MAX));
      end else if (tick) begin
         hpos_n        = H_BITS'(h_cand);
         vpos_n        = V_BITS'(v_cand);
         shift_left_n  = (h_cand < int'(hpos));
         shift_right_n = (h_cand > int'(hpos));
      end
   end

   // State, speed, position and the registered flags. Edge flags are derived
   // from the next position so they line up with hpos/vpos.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         speed       <= SPEED_W'(STEP_MIN);
         hold        <= '0;
         hpos        <= H_BITS'(H_INIT);
         vpos        <= V_BITS'(V_INIT);
         shift_left  <= 1'b0;
         shift_right <= 1'b0;
         at_h_edge   <= (H_INIT == H_MIN) || (H_INIT == H_MAX);
         at_v_edge   <= (V_INIT == V_MIN) || (V_INIT == V_MAX);
      end else begin
         state       <= state_n;
         speed       <= speed_n;
         hold        <= hold_n;
         hpos        <= hpos_n;
         vpos        <= vpos_n;
         shift_left  <= shift_left_n;
         shift_right <= shift_right_n;
         at_h_edge   <= (hpos_n == H_BITS'(H_MIN)) || (hpos_n == H_BITS'(H_MAX));
         at_v_edge   <= (vpos_n == V_BITS'(V_MIN)) || (vpos_n == V_BITS'(V_MAX));
      end
   end

   assign moving = (state != IDLE);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_motion_ctrl
// Directed bench for sprite_motion_ctrl with TICK_DIV=4, STEP 1..3,
// ACCEL_TICKS=2. Each table row is either a reset or one tick window: inputs
// are driven with count at 0, the tick falls in the fourth cycle and outputs
// are sampled on the falling edge after the window.
// -----------------------------------------------------------------------------
module tb_sprite_motion_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] keys;
   logic       load;
   logic [9:0] load_h;
   logic [9:0] load_v;
   logic [9:0] hpos;
   logic [9:0] vpos;
   logic       shift_left;
   logic       shift_right;
   logic       moving;
   logic       at_h_edge;
   logic       at_v_edge;

   int checks = 0;
   int passes = 0;

   typedef struct {
      bit         do_reset;
      logic [3:0] keys;
      logic       ld;
      logic [9:0] lh;
      logic [9:0] lv;
      int         eh;
      int         ev;
      bit         esl;
      bit         esr;
      bit         emv;
      bit         ehe;
      bit         eve;
   } vec_t;

   vec_t vecs[$];

   sprite_motion_ctrl #(
      .TICK_DIV    (4),
      .STEP_MIN    (1),
      .STEP_MAX    (3),
      .ACCEL_TICKS (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .keys        (keys),
      .load        (load),
      .load_h      (load_h),
      .load_v      (load_v),
      .hpos        (hpos),
      .vpos        (vpos),
      .shift_left  (shift_left),
      .shift_right (shift_right),
      .moving      (moving),
      .at_h_edge   (at_h_edge),
      .at_v_edge   (at_v_edge)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the run ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   function automatic vec_t mk(bit r, logic [3:0] k, logic ld, int lh, int lv,
                               int eh, int ev, bit esl, bit esr, bit emv,
                               bit ehe, bit eve);
      vec_t v;
      v.do_reset = r;
      v.keys     = k;
      v.ld       = ld;
      v.lh       = 10'(lh);
      v.lv       = 10'(lv);
      v.eh       = eh;
      v.ev       = ev;
      v.esl      = esl;
      v.esr      = esr;
      v.emv      = emv;
      v.ehe      = ehe;
      v.eve      = eve;
      return v;
   endfunction

   // One comparison against a bench-computed value.
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act == exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkAll(input string tag, input int eh, input int ev,
                           input bit esl, input bit esr, input bit emv,
                           input bit ehe, input bit eve);
      checkOutput({tag, "_hpos"}, int'(hpos), eh);
      checkOutput({tag, "_vpos"}, int'(vpos), ev);
      checkOutput({tag, "_shift_left"}, int'(shift_left), int'(esl));
      checkOutput({tag, "_shift_right"}, int'(shift_right), int'(esr));
      checkOutput({tag, "_moving"}, int'(moving), int'(emv));
      checkOutput({tag, "_at_h_edge"}, int'(at_h_edge), int'(ehe));
      checkOutput({tag, "_at_v_edge"}, int'(at_v_edge), int'(eve));
   endtask

   // Synchronous reset pulse; returns on a falling edge with rst low and the
   // divider count at 0.
   task automatic doReset();
      rst  = 1'b1;
      keys = 4'b0000;
      load = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One tick window. load (if requested) is held for the first cycle only;
   // the first cycle of the window must never carry a shift pulse.
   task automatic applyStimulus(input logic [3:0] k, input logic ld,
                                input logic [9:0] lh, input logic [9:0] lv,
                                input string tag);
      keys   = k;
      load   = ld;
      load_h = lh;
      load_v = lv;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      checkOutput({tag, "_pulse_width"}, int'(shift_left | shift_right), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst    = 1'b1;
      keys   = 4'b0000;
      load   = 1'b0;
      load_h = '0;
      load_v = '0;

      // Right held from reset, release, then press again at minimum speed.
      vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 200, 200, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 201, 200, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 202, 200, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 203, 200, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 205, 200, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 207, 200, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 210, 200, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 210, 200, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 211, 200, 0, 1, 1, 0, 0));
      // Diagonal up+left, then up+down+left cancels vertically.
      vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 200, 200, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 199, 199, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 198, 198, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 4'b0111, 0, 0, 0, 197, 198, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 4'b0111, 0, 0, 0, 195, 198, 1, 0, 1, 0, 0));
      // Left into H_MIN from 1, then a clamped vertical load and push down.
      vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 200, 200, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b0000, 1, 1, 200, 1, 200, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 200, 1, 0, 1, 1, 0));
      vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 200, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 200, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 4'b0000, 1, 5, 900, 5, 479, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 5, 479, 0, 0, 1, 0, 1));
      // Ramp to speed 3, jump to 637 and push right into H_MAX.
      vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 200, 200, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 201, 200, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 202, 200, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 203, 200, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 205, 200, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 207, 200, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 4'b1000, 1, 637, 200, 639, 200, 0, 1, 1, 1, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 639, 200, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 639, 200, 0, 0, 1, 1, 0));

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         if (vecs[i].do_reset) begin
            doReset();
         end else begin
            applyStimulus(vecs[i].keys, vecs[i].ld, vecs[i].lh, vecs[i].lv, tag);
         end
         checkAll(tag, vecs[i].eh, vecs[i].ev, vecs[i].esl, vecs[i].esr,
                  vecs[i].emv, vecs[i].ehe, vecs[i].eve);
      end

      // Load landing on the tick cycle while cruising: load wins, no pulse,
      // state kept; a release then returns to IDLE at minimum speed.
      doReset();
      for (int n = 0; n < 5; n++) begin
         applyStimulus(4'b1000, 1'b0, '0, '0, "ld_ramp");
      end
      checkOutput("ld_pre_hpos", int'(hpos), 207);
      repeat (3) @(posedge clk);
      @(negedge clk);
      load   = 1'b1;
      load_h = 10'd700;
      load_v = 10'd50;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      checkAll("ld_tick", 639, 50, 0, 0, 1, 1, 0);
      applyStimulus(4'b0000, 1'b0, '0, '0, "ld_release");
      checkAll("ld_release", 639, 50, 0, 0, 0, 1, 0);
      applyStimulus(4'b0010, 1'b0, '0, '0, "ld_restart");
      checkAll("ld_restart", 638, 50, 1, 0, 1, 0, 0);

      // Reset in CRUISE with the divider mid-count, then a 1-pixel move.
      doReset();
      for (int n = 0; n < 5; n++) begin
         applyStimulus(4'b1000, 1'b0, '0, '0, "rst_ramp");
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkAll("rst_mid", 200, 200, 0, 0, 0, 0, 0);
      applyStimulus(4'b1000, 1'b0, '0, '0, "rst_first");
      checkAll("rst_first", 201, 200, 0, 1, 1, 0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
